trace_recorder: RTL and testbench

Capture-and-compare end of the formal trace flow. It samples four 1-bit signals once per clock and writes them into 32-character ASCII trace strings, using `-` for high and `_` for low. The strings use the same encoding and bit ordering as the stimulus sequencer's trace parameters, so captured and expected traces compare directly. It checks each sample against an expected trace given as a parameter and raises a sticky mismatch with the first failing cycle and signal. Benches instantiate it beside the sequencer and the unit under test, so formal runs can check recorded waveforms as well as properties.

---
 rtl/trace_pkg.sv | 51 +++++
 rtl/trace_lane.sv | 44 ++++
 rtl/trace_recorder.sv | 121 ++++++++++++
 tb/tb_trace_recorder.sv | 175 +++++++++++++++++
 4 files changed

// File: rtl/trace_pkg.sv
// Shared character encoding, trace type and string helpers for the trace recorder.
// Both the recorder and its lanes import this package.
package trace_pkg;

    localparam int TRACE_LEN = 32;

    localparam logic [7:0] CH_HIGH  = 8'h2D;
    localparam logic [7:0] CH_LOW   = 8'h5F;
    localparam logic [7:0] CH_DC    = 8'h3F;
    localparam logic [7:0] CH_EMPTY = 8'h2E;

    typedef logic [TRACE_LEN*8-1:0] trace_t;

    typedef enum logic {
        ST_RECORD = 1'b0,
        ST_DONE   = 1'b1
    } rec_state_e;

    // Character 0 is the most significant byte of the string.
    function automatic logic [7:0] trace_char(input trace_t tr, input logic [4:0] idx);
        logic [4:0] pos;
        pos = 5'd31 - idx;
        return tr[{pos, 3'b000} +: 8];
    endfunction

    function automatic trace_t set_char(input trace_t tr, input logic [4:0] idx,
                                        input logic [7:0] ch);
        trace_t     res;
        logic [4:0] pos;
        res = tr;
        pos = 5'd31 - idx;
        res[{pos, 3'b000} +: 8] = ch;
        return res;
    endfunction

    function automatic logic [7:0] encode(input logic s);
        return s ? CH_HIGH : CH_LOW;
    endfunction

    // Unknown expected bytes behave like don't-care.
    function automatic logic char_mismatch(input logic [7:0] exp_ch, input logic s);
        logic res;
        case (exp_ch)
            CH_HIGH: res = ~s;
            CH_LOW:  res = s;
            default: res = 1'b0;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/trace_lane.sv
// One recorded signal: holds its trace string and flags a per-cycle mismatch
// against the expected string at the shared index.
module trace_lane
    import trace_pkg::*;
#(
    parameter trace_t expected = {TRACE_LEN{CH_DC}}
) (
    input  logic       clock,
    input  logic       resetn,
    input  logic       sample,
    input  logic [4:0] t,
    input  logic       done,
    output trace_t     rec,
    output logic       mis
);

    trace_t rec_r;
    logic   mis_s;

    // Record string: one character written per sampled cycle, frozen once done.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            rec_r <= {TRACE_LEN{CH_EMPTY}};
        end else if (!done) begin
            rec_r <= set_char(rec_r, t, encode(sample));
        end else begin
            rec_r <= rec_r;
        end
    end

    // Compare the live sample with the expected character for this cycle.
    always_comb begin
        mis_s = 1'b0;
        if (!done) begin
            mis_s = char_mismatch(trace_char(expected, t), sample);
        end else begin
            mis_s = 1'b0;
        end
    end

    assign rec = rec_r;
    assign mis = mis_s;

endmodule

// File: rtl/trace_recorder.sv
// Four-lane waveform recorder with a sticky first-mismatch report.
// Optional TRACE_RECORDER_ASSERT_EN adds a no-mismatch assertion and a done cover.
module trace_recorder
    import trace_pkg::*;
#(
    parameter trace_t trace_a = {TRACE_LEN{CH_DC}},
    parameter trace_t trace_b = {TRACE_LEN{CH_DC}},
    parameter trace_t trace_c = {TRACE_LEN{CH_DC}},
    parameter trace_t trace_d = {TRACE_LEN{CH_DC}}
) (
    input  logic         clock,
    input  logic         resetn,
    input  logic         A,
    input  logic         B,
    input  logic         C,
    input  logic         D,
    output logic [255:0] rec_a,
    output logic [255:0] rec_b,
    output logic [255:0] rec_c,
    output logic [255:0] rec_d,
    output logic [4:0]   t,
    output logic         done,
    output logic         mismatch,
    output logic [4:0]   mismatch_t,
    output logic [3:0]   mismatch_sig
);

    rec_state_e state_r;
    rec_state_e state_s;
    logic [4:0] t_r;
    logic       mismatch_r;
    logic [4:0] mismatch_t_r;
    logic [3:0] mismatch_sig_r;
    logic [3:0] mis_vec_s;
    logic       done_s;

    assign done_s = (state_r == ST_DONE);

    trace_lane #(.expected(trace_a)) u_lane_a (
        .clock(clock), .resetn(resetn), .sample(A), .t(t_r), .done(done_s),
        .rec(rec_a), .mis(mis_vec_s[0])
    );
    trace_lane #(.expected(trace_b)) u_lane_b (
        .clock(clock), .resetn(resetn), .sample(B), .t(t_r), .done(done_s),
        .rec(rec_b), .mis(mis_vec_s[1])
    );
    trace_lane #(.expected(trace_c)) u_lane_c (
        .clock(clock), .resetn(resetn), .sample(C), .t(t_r), .done(done_s),
        .rec(rec_c), .mis(mis_vec_s[2])
    );
    trace_lane #(.expected(trace_d)) u_lane_d (
        .clock(clock), .resetn(resetn), .sample(D), .t(t_r), .done(done_s),
        .rec(rec_d), .mis(mis_vec_s[3])
    );

    // State register.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_r <= ST_RECORD;
        end else begin
            state_r <= state_s;
        end
    end

    // Next state: leave RECORD on the edge that samples the last index.
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_RECORD: begin
                if (t_r == 5'd31) begin
                    state_s = ST_DONE;
                end else begin
                    state_s = ST_RECORD;
                end
            end
            ST_DONE: state_s = ST_DONE;
            default: state_s = ST_RECORD;
        endcase
    end

    // Cycle index saturates at 31; it is already 31 when done rises.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            t_r <= 5'd0;
        end else if ((state_r == ST_RECORD) && (t_r != 5'd31)) begin
            t_r <= t_r + 5'd1;
        end else begin
            t_r <= t_r;
        end
    end

    // First-mismatch latch; lane mismatch bits are already gated by done.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            mismatch_r     <= 1'b0;
            mismatch_t_r   <= 5'd0;
            mismatch_sig_r <= 4'd0;
        end else if (!mismatch_r && (mis_vec_s != 4'd0)) begin
            mismatch_r     <= 1'b1;
            mismatch_t_r   <= t_r;
            mismatch_sig_r <= mis_vec_s;
        end else begin
            mismatch_r     <= mismatch_r;
            mismatch_t_r   <= mismatch_t_r;
            mismatch_sig_r <= mismatch_sig_r;
        end
    end

    assign t            = t_r;
    assign done         = done_s;
    assign mismatch     = mismatch_r;
    assign mismatch_t   = mismatch_t_r;
    assign mismatch_sig = mismatch_sig_r;

`ifdef TRACE_RECORDER_ASSERT_EN
    no_mismatch_a: assert property (@(posedge clock) disable iff (!resetn) !mismatch);
    done_c: cover property (@(posedge clock) done);
`else
`endif

endmodule

// File: tb/tb_trace_recorder.sv
// Directed bench: three recorder instances with different expected traces
// share one clock and reset; expected strings are built by hand in the bench.
module tb_trace_recorder;
    import trace_pkg::*;

    localparam logic [255:0] T_EMPTY = {32{8'h2E}};
    localparam logic [255:0] T_LOW   = {32{8'h5F}};
    localparam logic [255:0] T_A     = {8'h5F, 8'h2D, {30{8'h5F}}};
    localparam logic [255:0] T_D     = {{7{8'h5F}}, 8'h2D, {24{8'h5F}}};
    localparam logic [255:0] T_D8    = {{8{8'h5F}}, 8'h2D, {23{8'h5F}}};
    localparam logic [255:0] T_A_T1  = {8'h5F, 8'h2D, {30{8'h2E}}};

    logic clock = 1'b0;
    logic resetn = 1'b0;
    logic a1 = 1'b0, b1 = 1'b0, c1 = 1'b0, d1 = 1'b0;
    logic a2 = 1'b0, b2 = 1'b0, c2 = 1'b0, d2 = 1'b0;
    logic a3 = 1'b0, b3 = 1'b0, c3 = 1'b0, d3 = 1'b0;

    logic [255:0] ra1, rb1, rc1, rd1, ra2, rb2, rc2, rd2, ra3, rb3, rc3, rd3;
    logic [4:0]   t1, t2, t3, mt1, mt2, mt3;
    logic         done1, done2, done3, mm1, mm2, mm3;
    logic [3:0]   ms1, ms2, ms3;

    logic [31:0]  rnd_b, rnd_c, rnd_d;
    logic [255:0] exp_b, exp_c, exp_d;
    int checks = 0;
    int errors = 0;

    always #5 clock = ~clock;

    trace_recorder #(.trace_a(T_A)) u1 (
        .clock(clock), .resetn(resetn), .A(a1), .B(b1), .C(c1), .D(d1),
        .rec_a(ra1), .rec_b(rb1), .rec_c(rc1), .rec_d(rd1), .t(t1), .done(done1),
        .mismatch(mm1), .mismatch_t(mt1), .mismatch_sig(ms1)
    );
    trace_recorder #(.trace_d(T_D)) u2 (
        .clock(clock), .resetn(resetn), .A(a2), .B(b2), .C(c2), .D(d2),
        .rec_a(ra2), .rec_b(rb2), .rec_c(rc2), .rec_d(rd2), .t(t2), .done(done2),
        .mismatch(mm2), .mismatch_t(mt2), .mismatch_sig(ms2)
    );
    trace_recorder #(.trace_a(T_LOW), .trace_b(T_LOW), .trace_c(T_LOW)) u3 (
        .clock(clock), .resetn(resetn), .A(a3), .B(b3), .C(c3), .D(d3),
        .rec_a(ra3), .rec_b(rb3), .rec_c(rc3), .rec_d(rd3), .t(t3), .done(done3),
        .mismatch(mm3), .mismatch_t(mt3), .mismatch_sig(ms3)
    );

    task automatic check_eq(input string tag, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    // Inputs for index k; beyond 31 every input toggles.
    task automatic drive(input int k);
        if (k < 32) begin
            a1 = (k == 1); b1 = rnd_b[k]; c1 = rnd_c[k]; d1 = rnd_d[k];
            a2 = 1'b0; b2 = 1'b0; c2 = 1'b0; d2 = (k == 8);
            a3 = (k == 5); b3 = (k == 9); c3 = (k == 5); d3 = 1'b0;
        end else begin
            a1 = (k % 2 == 1); b1 = a1; c1 = a1; d1 = a1;
            a2 = a1; b2 = a1; c2 = a1; d2 = a1;
            a3 = a1; b3 = a1; c3 = a1; d3 = a1;
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    initial begin
        rnd_b = $urandom();
        rnd_c = $urandom();
        rnd_d = $urandom();
        for (int i = 0; i < 32; i++) begin
            exp_b[8*(31-i) +: 8] = rnd_b[i] ? 8'h2D : 8'h5F;
            exp_c[8*(31-i) +: 8] = rnd_c[i] ? 8'h2D : 8'h5F;
            exp_d[8*(31-i) +: 8] = rnd_d[i] ? 8'h2D : 8'h5F;
        end

        drive(0);
        step();
        step();
        check_eq("rst_rec_a", ra1, T_EMPTY);
        check_eq("rst_rec_d", rd2, T_EMPTY);
        check_eq("rst_t", {251'd0, t1}, 256'd0);
        check_eq("rst_done", {255'd0, done1}, 256'd0);
        check_eq("rst_flags", {244'd0, mm3, mt3, ms3, 1'b0}, 256'd0);

        resetn = 1'b1;
        drive(0);
        for (int k = 0; k < 32; k++) begin
            step();
            if (k == 1) begin
                check_eq("partial_rec_a", ra1, T_A_T1);
                check_eq("t_after_1", {251'd0, t1}, 256'd2);
            end
            if (k == 5) begin
                check_eq("u3_mm_at5", {255'd0, mm3}, 256'd1);
                check_eq("u3_mt_at5", {251'd0, mt3}, 256'd5);
                check_eq("u3_ms_at5", {252'd0, ms3}, 256'h5);
            end
            if (k == 6) check_eq("u2_mm_before7", {255'd0, mm2}, 256'd0);
            if (k == 7) begin
                check_eq("u2_mm_at7", {255'd0, mm2}, 256'd1);
                check_eq("u2_mt_at7", {251'd0, mt2}, 256'd7);
            end
            if (k == 30) begin
                check_eq("t_at_30", {251'd0, t1}, 256'd31);
                check_eq("done_at_30", {255'd0, done1}, 256'd0);
            end
            if (k < 31) drive(k + 1);
        end

        check_eq("done_32", {255'd0, done1}, 256'd1);
        check_eq("t_final", {251'd0, t1}, 256'd31);
        check_eq("rec_a1", ra1, T_A);
        check_eq("rec_b1_rand", rb1, exp_b);
        check_eq("rec_c1_rand", rc1, exp_c);
        check_eq("rec_d1_rand", rd1, exp_d);
        check_eq("u1_mm", {255'd0, mm1}, 256'd0);
        check_eq("rec_d2", rd2, T_D8);
        check_eq("u2_mt", {251'd0, mt2}, 256'd7);
        check_eq("u2_ms", {252'd0, ms2}, 256'h8);
        check_eq("u3_mt_final", {251'd0, mt3}, 256'd5);
        check_eq("u3_ms_final", {252'd0, ms3}, 256'h5);

        for (int k = 32; k < 38; k++) begin
            drive(k);
            step();
        end
        check_eq("frz_rec_a", ra1, T_A);
        check_eq("frz_rec_b", rb1, exp_b);
        check_eq("frz_rec_d2", rd2, T_D8);
        check_eq("frz_t", {251'd0, t1}, 256'd31);
        check_eq("frz_done", {255'd0, done1}, 256'd1);
        check_eq("frz_u3", {244'd0, mm3, mt3, ms3, 1'b0}, {244'd0, 1'b1, 5'd5, 4'h5, 1'b0});
        check_eq("frz_u1_mm", {255'd0, mm1}, 256'd0);

        resetn = 1'b0;
        step();
        resetn = 1'b1;
        drive(0);
        for (int k = 0; k < 12; k++) begin
            step();
            drive(k + 1);
        end
        check_eq("mid_u3_mm", {255'd0, mm3}, 256'd1);
        check_eq("mid_t", {251'd0, t1}, 256'd12);
        resetn = 1'b0;
        #1;
        check_eq("mid_rst_rec_a", ra1, T_EMPTY);
        check_eq("mid_rst_rec_b", rb1, T_EMPTY);
        check_eq("mid_rst_t", {251'd0, t1}, 256'd0);
        check_eq("mid_rst_flags", {244'd0, mm2, mt2, ms2, done2}, 256'd0);
        step();
        step();
        resetn = 1'b1;
        drive(0);
        for (int k = 0; k < 32; k++) begin
            step();
            if (k == 30) check_eq("re_done_31", {255'd0, done1}, 256'd0);
            if (k < 31) drive(k + 1);
        end
        check_eq("re_done_32", {255'd0, done1}, 256'd1);
        check_eq("re_rec_a", ra1, T_A);
        check_eq("re_rec_c", rc1, exp_c);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
